// File: rtl/spi_flash_master_if.sv
// Host-side request/response bundle for spi_flash_master.
// The host owns the master modport; the SPI engine owns the slave modport.
interface spi_flash_master_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic              ready;
    logic [DATA_W-1:0] tx_data;
    logic [1:0]        mode;
    logic              hold_cs;
    logic              release_cs;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;

    modport master (
        output start, tx_data, mode, hold_cs, release_cs,
        input  ready, rx_data, rx_valid, busy
    );

    modport slave (
        input  start, tx_data, mode, hold_cs, release_cs,
        output ready, rx_data, rx_valid, busy
    );
endinterface

// File: rtl/spi_flash_master.sv
// Single-word SPI master with programmable mode and divider, plus a CS-hold
// state so multi-word flash commands can run under one chip-select assertion.
module spi_flash_master #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_flash_master_if.slave host,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              spi_ss_n
);
    localparam int                EDGES      = 2 * DATA_W;
    localparam int                EDGE_W     = $clog2(EDGES + 1);
    localparam logic [7:0]        DIV_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST  = EDGE_W'(EDGES - 1);
    localparam logic [EDGE_W-1:0] EDGE_DONE  = EDGE_W'(EDGES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_XFER,
        S_TAIL,
        S_GAP,
        S_HOLD
    } state_t;

    state_t              state_reg, state_next;
    logic [7:0]          div_reg, div_next;
    logic [EDGE_W-1:0]   edge_reg, edge_next;
    logic                cpol_reg, cpol_next;
    logic                cpha_reg, cpha_next;
    logic                hold_reg, hold_next;
    // MSB goes straight to mosi on accept, so only the remaining bits are kept
    logic [DATA_W-2:0]   tx_reg, tx_next;
    logic [DATA_W-1:0]   rx_shift_reg, rx_shift_next;
    logic [DATA_W-1:0]   rx_data_reg, rx_data_next;
    logic                rx_valid_reg, rx_valid_next;
    logic                ready_reg, ready_next;
    logic                busy_reg, busy_next;
    logic                sck_reg, sck_next;
    logic                mosi_reg, mosi_next;
    logic                ss_n_reg, ss_n_next;

    logic                accept;
    logic                div_tick;
    logic                do_edge;
    logic                leading;
    logic [EDGE_W-1:0]   edge_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            div_reg      <= '0;
            edge_reg     <= '0;
            cpol_reg     <= 1'b0;
            cpha_reg     <= 1'b0;
            hold_reg     <= 1'b0;
            tx_reg       <= '0;
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            sck_reg      <= 1'b0;
            mosi_reg     <= 1'b0;
            ss_n_reg     <= 1'b1;
        end else begin
            state_reg    <= state_next;
            div_reg      <= div_next;
            edge_reg     <= edge_next;
            cpol_reg     <= cpol_next;
            cpha_reg     <= cpha_next;
            hold_reg     <= hold_next;
            tx_reg       <= tx_next;
            rx_shift_reg <= rx_shift_next;
            rx_data_reg  <= rx_data_next;
            rx_valid_reg <= rx_valid_next;
            ready_reg    <= ready_next;
            busy_reg     <= busy_next;
            sck_reg      <= sck_next;
            mosi_reg     <= mosi_next;
            ss_n_reg     <= ss_n_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        edge_next     = edge_reg;
        cpol_next     = cpol_reg;
        cpha_next     = cpha_reg;
        hold_next     = hold_reg;
        tx_next       = tx_reg;
        rx_shift_next = rx_shift_reg;
        rx_data_next  = rx_data_reg;
        rx_valid_next = 1'b0;
        sck_next      = sck_reg;
        mosi_next     = mosi_reg;
        ss_n_next     = ss_n_reg;

        div_tick = (div_reg == 8'd0);
        div_next = div_tick ? div_reg : (div_reg - 8'd1);
        accept   = host.start && ready_reg;
        edge_now = (state_reg == S_LEAD) ? '0 : edge_reg;
        do_edge  = div_tick && ((state_reg == S_LEAD) ||
                                ((state_reg == S_XFER) && (edge_reg != EDGE_DONE)));
        leading  = ~edge_now[0];

        case (state_reg)
            S_IDLE: begin
                sck_next = cpol_reg;
                if (accept) begin
                    state_next = S_LEAD;
                    div_next   = DIV_RELOAD;
                    cpol_next  = host.mode[1];
                    cpha_next  = host.mode[0];
                    sck_next   = host.mode[1];
                    hold_next  = host.hold_cs;
                    tx_next    = host.tx_data[DATA_W-2:0];
                    mosi_next  = host.tx_data[DATA_W-1];
                    ss_n_next  = 1'b0;
                end
            end
            S_HOLD: begin
                // a start in the same cycle as release keeps the chip selected
                if (accept) begin
                    state_next = S_LEAD;
                    div_next   = DIV_RELOAD;
                    hold_next  = host.hold_cs;
                    tx_next    = host.tx_data[DATA_W-2:0];
                    mosi_next  = host.tx_data[DATA_W-1];
                end else if (host.release_cs) begin
                    state_next = S_TAIL;
                    div_next   = DIV_RELOAD;
                end
            end
            S_LEAD: begin
                if (div_tick) begin
                    state_next = S_XFER;
                    div_next   = DIV_RELOAD;
                end
            end
            S_XFER: begin
                if (div_tick) begin
                    div_next = DIV_RELOAD;
                    if (edge_reg == EDGE_DONE) begin
                        rx_data_next  = rx_shift_reg;
                        rx_valid_next = 1'b1;
                        state_next    = hold_reg ? S_HOLD : S_TAIL;
                    end
                end
            end
            S_TAIL: begin
                if (div_tick) begin
                    state_next = S_GAP;
                    div_next   = DIV_RELOAD;
                    ss_n_next  = 1'b1;
                end
            end
            S_GAP: begin
                if (div_tick) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Sample on the phase-selected edge, shift on the other one; the MSB is
        // already on mosi, so the first CPHA=1 leading edge and the final CPHA=0
        // trailing edge do not shift.
        if (do_edge) begin
            sck_next  = ~sck_reg;
            edge_next = edge_now + EDGE_W'(1);
            if (leading ^ cpha_reg) begin
                rx_shift_next = {rx_shift_reg[DATA_W-2:0], spi_miso};
            end else if (!(cpha_reg ? (edge_now == '0) : (edge_now == EDGE_LAST))) begin
                mosi_next = tx_reg[DATA_W-2];
                tx_next   = {tx_reg[DATA_W-3:0], 1'b0};
            end
        end

        ready_next = (state_next == S_IDLE) || (state_next == S_HOLD);
        busy_next  = (state_next != S_IDLE);
    end

    assign host.ready    = ready_reg;
    assign host.busy     = busy_reg;
    assign host.rx_data  = rx_data_reg;
    assign host.rx_valid = rx_valid_reg;
    assign spi_sck       = sck_reg;
    assign spi_mosi      = mosi_reg;
    assign spi_ss_n      = ss_n_reg;
endmodule

// File: tb/tb_spi_flash_master.sv
// Self-checking bench: a timeline model of each word (edge times, chip-select
// window, handshake) plus SPI slave / loopback / random-miso data sources.
`timescale 1ns/1ps
module tb_spi_flash_master;
    localparam int DW  = 8;
    localparam int CD  = 2;
    localparam int DW2 = 16;
    localparam int CD2 = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    spi_flash_master_if #(.DATA_W(DW))  bus_a ();
    spi_flash_master_if #(.DATA_W(DW2)) bus_b ();

    logic sck_a, mosi_a, miso_a, ss_a;
    logic sck_b, mosi_b, ss_b;
    logic loop_en = 1'b1;
    logic miso_tb = 1'b0;
    assign miso_a = loop_en ? mosi_a : miso_tb;

    spi_flash_master #(.DATA_W(DW), .CLK_DIV(CD)) dut_a (
        .clk(clk), .rst_n(rst_n), .host(bus_a),
        .spi_sck(sck_a), .spi_mosi(mosi_a), .spi_miso(miso_a), .spi_ss_n(ss_a)
    );

    spi_flash_master #(.DATA_W(DW2), .CLK_DIV(CD2)) dut_b (
        .clk(clk), .rst_n(rst_n), .host(bus_b),
        .spi_sck(sck_b), .spi_mosi(mosi_b), .spi_miso(mosi_b), .spi_ss_n(ss_b)
    );

    int vectors = 0;
    int miscompares = 0;

    initial begin
        #500000;
        $display("FAIL watchdog expired got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready_a();
        int guard = 0;
        while (bus_a.ready !== 1'b1 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        vectors++;
        if (bus_a.ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_wait got %b expected 1", bus_a.ready);
        end
    endtask

    // One word on dut_a. src: 0 loopback, 1 slave returning slave_word, 2 random miso.
    task automatic do_word(input logic [1:0] md, input logic [1:0] cap_md, input logic [7:0] tx,
                           input logic hc, input int src, input logic [7:0] slave_word,
                           input int poke_t);
        int xend, tend, nshift, idx, n, te, b;
        int bad_sck, bad_ss, bad_rxv, bad_rdy, bad_busy;
        logic sck_h [0:63];
        logic mosi_h[0:63];
        logic miso_h[0:63];
        logic ss_h  [0:63];
        logic rdy_h [0:63];
        logic busy_h[0:63];
        logic rxv_h [0:63];
        logic [7:0] rxd, exp_rx, hist_rx, mosi_bits;
        logic cpol, cpha, e;
        cpol = cap_md[1];
        cpha = cap_md[0];
        xend = CD * (2 * DW + 1);
        tend = hc ? xend : xend + 2 * CD;
        wait_ready_a();
        bus_a.start   = 1'b1;
        bus_a.tx_data = tx;
        bus_a.mode    = md;
        bus_a.hold_cs = hc;
        loop_en = (src == 0);
        miso_tb = (src == 1) ? slave_word[7] : 1'($urandom_range(0, 1));
        nshift = 0;
        rxd = '0;
        @(posedge clk); #1;
        bus_a.start      = 1'b0;
        bus_a.release_cs = 1'b0;
        for (int t = 0; t <= tend; t++) begin
            if (t > 0) begin
                @(posedge clk); #1;
            end
            sck_h[t]  = sck_a;
            mosi_h[t] = mosi_a;
            ss_h[t]   = ss_a;
            rdy_h[t]  = bus_a.ready;
            busy_h[t] = bus_a.busy;
            rxv_h[t]  = bus_a.rx_valid;
            if (t == xend) rxd = bus_a.rx_data;
            if (src == 1 && t > 0 && sck_h[t] !== sck_h[t-1]) begin
                if ((sck_h[t] !== cpol) == cpha) begin
                    nshift++;
                    idx = cpha ? nshift - 1 : nshift;
                    if (idx < DW) miso_tb = slave_word[DW-1-idx];
                end
            end
            if (src == 2) miso_tb = 1'($urandom_range(0, 1));
            miso_h[t] = loop_en ? mosi_a : miso_tb;
            if (t == poke_t) begin
                bus_a.start   = 1'b1;
                bus_a.tx_data = 8'hFF;
                bus_a.mode    = ~md;
                bus_a.hold_cs = ~hc;
            end else if (t == poke_t + 1) begin
                bus_a.start = 1'b0;
            end
        end

        bad_sck = -1; bad_ss = -1; bad_rxv = -1; bad_rdy = -1; bad_busy = -1;
        for (int t = 0; t <= tend; t++) begin
            n = t / CD;
            if (n > 2 * DW) n = 2 * DW;
            e = cpol ^ n[0];
            if (sck_h[t] !== e && bad_sck < 0) bad_sck = t;
            e = hc ? 1'b0 : (t >= xend + CD);
            if (ss_h[t] !== e && bad_ss < 0) bad_ss = t;
            e = (t == xend);
            if (rxv_h[t] !== e && bad_rxv < 0) bad_rxv = t;
            e = hc ? (t >= xend) : (t >= xend + 2 * CD);
            if (rdy_h[t] !== e && bad_rdy < 0) bad_rdy = t;
            e = hc ? 1'b1 : (t < xend + 2 * CD);
            if (busy_h[t] !== e && bad_busy < 0) bad_busy = t;
        end
        vectors++;
        if (bad_sck >= 0) begin
            miscompares++;
            $display("FAIL sck_wave t=%0d got %b (cpol %b)", bad_sck, sck_h[bad_sck], cpol);
        end
        vectors++;
        if (bad_ss >= 0) begin
            miscompares++;
            $display("FAIL ss_window t=%0d got %b hold=%b", bad_ss, ss_h[bad_ss], hc);
        end
        vectors++;
        if (bad_rxv >= 0) begin
            miscompares++;
            $display("FAIL rx_valid_pulse t=%0d got %b expected pulse only at %0d", bad_rxv, rxv_h[bad_rxv], xend);
        end
        vectors++;
        if (bad_rdy >= 0) begin
            miscompares++;
            $display("FAIL ready_timing t=%0d got %b hold=%b", bad_rdy, rdy_h[bad_rdy], hc);
        end
        vectors++;
        if (bad_busy >= 0) begin
            miscompares++;
            $display("FAIL busy_timing t=%0d got %b hold=%b", bad_busy, busy_h[bad_busy], hc);
        end

        mosi_bits = '0;
        hist_rx = '0;
        for (int j = 0; j < 2 * DW; j++) begin
            if (((j % 2) == 0) == (cpha == 1'b0)) begin
                te = CD * (j + 1);
                b = j / 2;
                mosi_bits[DW-1-b] = mosi_h[te-1];
                hist_rx[DW-1-b]   = miso_h[te-1];
            end
        end
        exp_rx = (src == 0) ? tx : (src == 1) ? slave_word : hist_rx;
        vectors++;
        if (mosi_bits !== tx) begin
            miscompares++;
            $display("FAIL mosi_bits got %02h expected %02h mode %0d", mosi_bits, tx, cap_md);
        end
        vectors++;
        if (rxd !== exp_rx) begin
            miscompares++;
            $display("FAIL rx_data got %02h expected %02h mode %0d", rxd, exp_rx, cap_md);
        end
        $display("word mode=%0d tx=%02h hold=%0d src=%0d rx=%02h", cap_md, tx, hc, src, rxd);
    endtask

    // Called while dut_a sits in HOLD.
    task automatic do_release();
        logic es, er;
        bus_a.release_cs = 1'b1;
        @(posedge clk); #1;
        bus_a.release_cs = 1'b0;
        for (int t = 0; t <= 2 * CD; t++) begin
            if (t > 0) begin
                @(posedge clk); #1;
            end
            es = (t >= CD);
            er = (t >= 2 * CD);
            vectors++;
            if (ss_a !== es || bus_a.ready !== er) begin
                miscompares++;
                $display("FAIL release t=%0d got ss=%b ready=%b expected ss=%b ready=%b", t, ss_a, bus_a.ready, es, er);
            end
        end
        $display("release done");
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (ss_a !== 1'b1 || sck_a !== 1'b0 || mosi_a !== 1'b0 || bus_a.rx_data !== 8'h00 ||
            bus_a.rx_valid !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got ss=%b sck=%b mosi=%b rx=%02h rxv=%b busy=%b ready=%b expected 1 0 0 00 0 0 0",
                     ss_a, sck_a, mosi_a, bus_a.rx_data, bus_a.rx_valid, bus_a.busy, bus_a.ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if (bus_a.ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_before_edge got %b expected 0", bus_a.ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus_a.ready !== 1'b1 || bus_a.busy !== 1'b0 || ss_a !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_reset got ready=%b busy=%b ss=%b expected 1 0 1", bus_a.ready, bus_a.busy, ss_a);
        end
        $display("reset sequence done");
    endtask

    task automatic test_mode0_basic();
        do_word(2'd0, 2'd0, 8'h9F, 1'b0, 1, 8'hC2, -1);
    endtask

    task automatic test_modes();
        for (int m = 1; m < 4; m++) do_word(2'(m), 2'(m), 8'hA5, 1'b0, 0, 8'h00, -1);
        vectors++;
        if (sck_a !== 1'b1) begin
            miscompares++;
            $display("FAIL sck_idle_cpol got %b expected 1", sck_a);
        end
    endtask

    task automatic test_random_words();
        logic [1:0] md;
        for (int i = 0; i < 4; i++) begin
            md = 2'($urandom_range(0, 3));
            do_word(md, md, 8'($urandom), 1'b0, 2, 8'h00, -1);
        end
    endtask

    task automatic test_hold_chain();
        do_word(2'd1, 2'd1, 8'h03, 1'b1, 0, 8'h00, -1);
        bus_a.release_cs = 1'b1;
        do_word(2'd2, 2'd1, 8'h00, 1'b1, 0, 8'h00, -1);
        do_word(2'd3, 2'd1, 8'h10, 1'b1, 1, 8'h5A, -1);
        do_release();
    endtask

    task automatic test_start_while_busy();
        int bad = 0;
        do_word(2'd0, 2'd0, 8'($urandom), 1'b0, 0, 8'h00, CD * 5);
        for (int t = 0; t < 6; t++) begin
            @(posedge clk); #1;
            if (ss_a !== 1'b1 || bus_a.rx_valid !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL busy_start_ignored got %0d active cycles expected 0", bad);
        end
    endtask

    task automatic test_reset_mid_xfer();
        int bad = 0;
        wait_ready_a();
        loop_en = 1'b1;
        bus_a.start   = 1'b1;
        bus_a.mode    = 2'd3;
        bus_a.tx_data = 8'($urandom);
        bus_a.hold_cs = 1'b0;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        repeat (CD * 8 + 1) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (ss_a !== 1'b1 || sck_a !== 1'b0 || mosi_a !== 1'b0 || bus_a.rx_data !== 8'h00 ||
            bus_a.rx_valid !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.ready !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_outputs got ss=%b sck=%b mosi=%b rx=%02h rxv=%b busy=%b ready=%b",
                     ss_a, sck_a, mosi_a, bus_a.rx_data, bus_a.rx_valid, bus_a.busy, bus_a.ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (bus_a.ready !== 1'b1 || sck_a !== 1'b0 || ss_a !== 1'b1) begin
            miscompares++;
            $display("FAIL post_abort_idle got ready=%b sck=%b ss=%b expected 1 0 1", bus_a.ready, sck_a, ss_a);
        end
        for (int t = 0; t < 40; t++) begin
            @(posedge clk); #1;
            if (bus_a.rx_valid !== 1'b0 || ss_a !== 1'b1 || sck_a !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL abort_quiet got %0d active cycles expected 0", bad);
        end
        $display("reset mid-transfer done");
        do_word(2'd0, 2'd0, 8'h6C, 1'b0, 1, 8'h3B, -1);
    endtask

    task automatic test_wide();
        logic [15:0] tx, rxd;
        logic [1:0] md;
        logic prev, tog, exp_t;
        int xend2, toggles, bad_pat, nrxv, guard, bad_end;
        xend2 = CD2 * (2 * DW2 + 1);
        for (int w = 0; w < 3; w++) begin
            tx = 16'($urandom);
            if (w == 0) tx = 16'h1234;
            md = 2'($urandom_range(0, 3));
            guard = 0;
            while (bus_b.ready !== 1'b1 && guard < 200) begin
                @(posedge clk); #1;
                guard++;
            end
            bus_b.start   = 1'b1;
            bus_b.tx_data = tx;
            bus_b.mode    = md;
            bus_b.hold_cs = 1'b0;
            @(posedge clk); #1;
            bus_b.start = 1'b0;
            toggles = 0; bad_pat = 0; nrxv = 0; bad_end = 0; rxd = '0;
            prev = md[1];
            for (int t = 0; t <= xend2 + 2 * CD2; t++) begin
                if (t > 0) begin
                    @(posedge clk); #1;
                end
                tog = (sck_b !== prev);
                exp_t = (t >= 1 && t <= 2 * DW2);
                if (tog) toggles++;
                if (tog !== exp_t) bad_pat++;
                prev = sck_b;
                if (bus_b.rx_valid === 1'b1) begin
                    nrxv++;
                    if (t != xend2) bad_end++;
                    rxd = bus_b.rx_data;
                end
                if (t == xend2 + CD2 && ss_b !== 1'b1) bad_end++;
                if (t == xend2 + 2 * CD2 && bus_b.ready !== 1'b1) bad_end++;
            end
            vectors++;
            if (toggles != 2 * DW2 || bad_pat != 0) begin
                miscompares++;
                $display("FAIL wide_sck got %0d edges %0d off-pattern expected 32 edges at clk/2", toggles, bad_pat);
            end
            vectors++;
            if (rxd !== tx || nrxv != 1) begin
                miscompares++;
                $display("FAIL wide_rx got %04h (%0d pulses) expected %04h (1 pulse)", rxd, nrxv, tx);
            end
            vectors++;
            if (bad_end != 0) begin
                miscompares++;
                $display("FAIL wide_timing got %0d misplaced events expected 0", bad_end);
            end
            $display("wide word mode=%0d tx=%04h rx=%04h", md, tx, rxd);
        end
    endtask

    task automatic test_back_to_back();
        logic in_hold = 1'b0;
        logic [1:0] cap = 2'd0;
        logic [1:0] md;
        logic hc;
        for (int i = 0; i < 6; i++) begin
            md = 2'($urandom_range(0, 3));
            hc = 1'($urandom_range(0, 1));
            if (!in_hold) cap = md;
            do_word(md, cap, 8'($urandom), hc, int'($urandom_range(0, 2)), 8'($urandom), -1);
            in_hold = hc;
        end
        if (in_hold) do_release();
    endtask

    initial begin
        bus_a.start = 1'b0; bus_a.tx_data = '0; bus_a.mode = 2'd0;
        bus_a.hold_cs = 1'b0; bus_a.release_cs = 1'b0;
        bus_b.start = 1'b0; bus_b.tx_data = '0; bus_b.mode = 2'd0;
        bus_b.hold_cs = 1'b0; bus_b.release_cs = 1'b0;
        test_reset();
        test_mode0_basic();
        test_modes();
        test_random_words();
        test_hold_chain();
        test_start_while_busy();
        test_reset_mid_xfer();
        test_wide();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
